// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file: the write-port
// priority select and the even-parity generator used by the optional parity build.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int N_REG_DEF = 32;
  localparam int MAX_WR    = 16;
  localparam int WR_IDX_W  = $clog2(MAX_WR);
  localparam int MAX_XLEN  = 128;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] idx;
  } wr_sel_t;

  // Ascending scan: the last matching port seen is the highest index, which wins.
  function automatic wr_sel_t wr_sel(input logic [MAX_WR-1:0] match);
    wr_sel_t s;
    s = '0;
    for (int k = 0; k < MAX_WR; k++) begin
      if (match[k]) begin
        s.hit = 1'b1;
        s.idx = WR_IDX_W'(k);
      end
    end
    return s;
  endfunction

  function automatic logic even_parity(input logic [MAX_XLEN-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, set wins.
// o_busy_next is the post-edge value so read ports can sample it with the data.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int N_REG = N_REG_DEF,
  parameter int N_WR  = 2,
  parameter int AW    = $clog2(N_REG)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_WR-1:0]    i_wr_en,
  input  logic [N_WR*AW-1:0] i_wr_rd,
  input  logic             i_issue_valid,
  input  logic [AW-1:0]    i_issue_rd,
  output logic [N_REG-1:0] o_busy_next,
  output logic [N_REG-1:0] o_busy_vec
);

  logic [N_REG-1:0] r_busy;
  logic [N_REG-1:0] w_busy_next;

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    w_busy_next = r_busy;
    for (int k = 0; k < N_WR; k++) begin
      if (i_wr_en[k]) w_busy_next[i_wr_rd[k*AW +: AW]] = 1'b0;
    end
    if (i_issue_valid) w_busy_next[i_issue_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking stays in always_comb.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_busy <= '0;
    else          r_busy <= w_busy_next;
  end

  assign o_busy_next = w_busy_next;
  assign o_busy_vec  = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with registered, write-bypassed reads, x0 tied to
// zero and a busy scoreboard. Define REGFILE_PARITY_EN to add per-register parity.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int N_REG = N_REG_DEF,
  parameter int N_RD  = 2,
  parameter int N_WR  = 2,
  localparam int AW   = $clog2(N_REG)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_WR-1:0]      i_wr_en,
  input  logic [N_WR*AW-1:0]   i_wr_rd,
  input  logic [N_WR*XLEN-1:0] i_wr_data,
  input  logic [N_RD*AW-1:0]   i_rd_addr,
  output logic [N_RD*XLEN-1:0] o_rd_data,
  output logic [N_RD-1:0]      o_rd_busy,
  input  logic                 i_issue_valid,
  input  logic [AW-1:0]        i_issue_rd,
  output logic [N_REG-1:0]     o_busy_vec
`ifdef REGFILE_PARITY_EN
  ,
  output logic [N_RD-1:0]      o_par_err
`endif
);

  logic [XLEN-1:0]      r_regs [N_REG];
  logic [XLEN-1:0]      w_next [N_REG];
  wr_sel_t              w_sel  [N_REG];
  logic [N_RD*XLEN-1:0] r_rd_data;
  logic [N_RD-1:0]      r_rd_busy;
  logic [N_REG-1:0]     w_busy_next;

  // Post-edge value of every register; reads index this, which yields the bypass.
  always_comb begin
    for (int r = 0; r < N_REG; r++) begin : g_next
      logic [MAX_WR-1:0] match;
      match = '0;
      for (int k = 0; k < N_WR; k++) begin
        match[k] = i_wr_en[k] && (i_wr_rd[k*AW +: AW] == AW'(r));
      end
      w_sel[r]  = (r == 0) ? '0 : wr_sel(match);
      w_next[r] = w_sel[r].hit ? i_wr_data[int'(w_sel[r].idx)*XLEN +: XLEN] : r_regs[r];
    end
    w_next[0] = '0;
  end

  // NOTE: the register array sits in the reset branch because reset must clear architectural state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < N_REG; r++) r_regs[r] <= '0;
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      for (int r = 0; r < N_REG; r++) r_regs[r] <= w_next[r];
      for (int p = 0; p < N_RD; p++) begin
        r_rd_data[p*XLEN +: XLEN] <= w_next[i_rd_addr[p*AW +: AW]];
        r_rd_busy[p]              <= w_busy_next[i_rd_addr[p*AW +: AW]];
      end
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_rd_busy = r_rd_busy;

  reg_scoreboard #(
    .N_REG (N_REG),
    .N_WR  (N_WR),
    .AW    (AW)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wr_en       (i_wr_en),
    .i_wr_rd       (i_wr_rd),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .o_busy_next   (w_busy_next),
    .o_busy_vec    (o_busy_vec)
  );

`ifdef REGFILE_PARITY_EN
  logic            r_par [N_REG];
  logic            w_par_next [N_REG];
  logic [N_RD-1:0] r_par_err;
  logic [N_RD-1:0] w_par_err;

  always_comb begin
    for (int r = 0; r < N_REG; r++) begin
      w_par_next[r] = w_sel[r].hit ?
        even_parity(MAX_XLEN'(i_wr_data[int'(w_sel[r].idx)*XLEN +: XLEN])) : r_par[r];
    end
    w_par_next[0] = 1'b0;
    // Bypassed and x0 reads deliver fresh data, so only stored reads are checked.
    for (int p = 0; p < N_RD; p++) begin
      w_par_err[p] = (i_rd_addr[p*AW +: AW] != '0) && !w_sel[i_rd_addr[p*AW +: AW]].hit &&
        (even_parity(MAX_XLEN'(r_regs[i_rd_addr[p*AW +: AW]])) != r_par[i_rd_addr[p*AW +: AW]]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < N_REG; r++) r_par[r] <= 1'b0;
      r_par_err <= '0;
    end else begin
      for (int r = 0; r < N_REG; r++) r_par[r] <= w_par_next[r];
      r_par_err <= w_par_err;
    end
  end

  assign o_par_err = r_par_err;
`endif

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core; successor to the single-write, two-read register file.
- Sits between decode (read addresses, issue) and writeback (write ports).
- Provides N_RD registered read ports with same-cycle write-to-read bypass on every write port, and x0 hardwired to zero.
- Adds a per-register busy scoreboard so decode can detect RAW hazards against in-flight producers.

Parameters:
- XLEN, 32, data width of each register.
- N_REG, 32, number of architectural registers (power of two, >=2); AW = $clog2(N_REG).
- N_RD, 2, number of read ports.
- N_WR, 2, number of write ports; a higher index has higher priority.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wr_en  in  N_WR  per-write-port enable.
- i_wr_rd  in  N_WR*AW  write addresses, port k at [k*AW +: AW].
- i_wr_data  in  N_WR*XLEN  write data, port k at [k*XLEN +: XLEN].
- i_rd_addr  in  N_RD*AW  read addresses.
- o_rd_data  out  N_RD*XLEN  registered read data.
- o_rd_busy  out  N_RD  registered busy flag of the addressed register.
- i_issue_valid  in  1  instruction issued with a destination register.
- i_issue_rd  in  AW  destination of the issued instruction.
- o_busy_vec  out  N_REG  current scoreboard, combinational from flops.
- o_par_err  out  N_RD  read parity error; present only with the optional feature.

Behaviour:
- Reset (async, i_rst_n=0): all registers = 0, all busy bits = 0, o_rd_data = 0, o_rd_busy = 0, o_par_err = 0. Reset may assert at any cycle, including mid-write; all state clears immediately.
- Write: on a rising edge, for each k with i_wr_en[k]=1 and i_wr_rd[k]!=0, reg[i_wr_rd[k]] <= i_wr_data[k].
- Write collision: if several enabled ports target the same rd, the highest k wins.
- Writes to x0 are ignored; reg[0] always reads 0.
- Read: latency 1 cycle. o_rd_data[p] at edge t+1 = value reg[i_rd_addr[p]] will hold after the writes of edge t. This means a bypass from the winning write port when addresses match; highest-k priority applies to the bypass as well.
- Read of x0 returns 0 even if a write targets 0.
- Read ports are independent; any number may address the same register.
- Scoreboard, per register r != 0:
  - set when i_issue_valid and i_issue_rd==r;
  - cleared when any enabled write port targets r;
  - set and clear in the same cycle: set wins, because the new producer is younger.
  - busy[0] is constant 0; issue to x0 is ignored.
- o_rd_busy[p] at t+1 = busy[i_rd_addr[p]] after the edge-t update, consistent with the bypassed data.
- Widths: addresses are exactly AW bits. No sign or zero extension; data passes through unmodified.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- Defined:
  - each register stores an extra even-parity bit computed from write data;
  - on read, parity is recomputed on the stored data;
  - o_par_err[p] is registered with o_rd_data and asserts for one cycle on mismatch;
  - bypassed reads and x0 reads never flag an error;
  - a parity error does not alter stored state.
- Undefined: no parity storage, and the o_par_err port is absent.

Decomposition:
- Package regfile_pkg: default XLEN/N_REG constants; a function for the highest-priority write select per address; parity function.
- Natural sub-module: reg_scoreboard (busy vector, set/clear priority, o_busy_vec). The storage and read/bypass logic stay in reg_file_mp.

Test Plan:
- Reset then read all 32 registers on both ports -> every o_rd_data = 0 and o_rd_busy = 0, one cycle after each address is applied.
- Write port0 x5=0xDEADBEEF while port1 reads x5 in the same cycle -> o_rd_data[1] = 0xDEADBEEF on the next edge (bypass); a later read also returns 0xDEADBEEF.
- Both write ports target x7 with 0x11111111 and 0x22222222 -> x7 = 0x22222222, and the bypassed read returns 0x22222222.
- Write 0xFFFFFFFF to x0 while reading x0 -> read returns 0, and x0 stays 0 afterwards.
- Issue rd=x9, then a writeback to x9 together with a new issue rd=x9 in the same cycle -> busy[9] remains 1; a later writeback alone clears it. Mid-sequence async reset clears o_busy_vec to 0 immediately.
- With REGFILE_PARITY_EN: force-flip a stored bit of x3 via hierarchical reference, then read x3 -> o_par_err = 1 for exactly one cycle; a bypassed read of x3 shows no error.
